sll_seq_32: RTL

// - Multi-cycle logical LEFT shifter for SLL/SLLV; complements the combinational right shifter in the ALU shift path.
// - Resolves one shamt bit per clock, MSB stage first (16, 8, 4, 2, 1).
// - Start/done handshake so the control unit can stall the ALU stage while a shift is in flight.

---
 rtl/sll_seq_32.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sll_seq_32.sv
// sll_seq_32: multi-cycle logical left shifter for SLL/SLLV.
// Resolves one shamt bit per clock, MSB stage first, behind a start/done
// handshake so the control unit can stall the ALU stage during a shift.
// Latency is fixed: done pulses SBits+1 cycles after the accepted start.
//
// Ports:
//   clk                  in   1      rising-edge clock
//   reset                in   1      synchronous, active-high
//   in_rotate            in   1      rotate-left select (SLL_ROTATE_EN only)
//   in_start             in   1      request, sampled only while out_ready=1
//   in_data_32           in   NBits  operand, captured on accepted start
//   in_shamt_5           in   SBits  shift amount, captured on accepted start
//   out_ready            out  1      high only in IDLE
//   out_busy             out  1      high only in SHIFT
//   out_done             out  1      one-cycle result-valid pulse
//   out_shifted_data_32  out  NBits  result, held until the next accepted start
//
// Build option: define SLL_ROTATE_EN to add in_rotate (ROTL support).

module sll_seq_32 #(
  parameter int unsigned NBits = 32,
  parameter int unsigned SBits = 5
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SLL_ROTATE_EN
  input  logic             in_rotate,
`endif
  input  logic             in_start,
  input  logic [NBits-1:0] in_data_32,
  input  logic [SBits-1:0] in_shamt_5,
  output logic             out_ready,
  output logic             out_busy,
  output logic             out_done,
  output logic [NBits-1:0] out_shifted_data_32
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [SBits-1:0] STAGE_FIRST = SBits'(SBits - 1);

  logic [1:0]       r_state;
  logic [NBits-1:0] r_acc;
  logic [SBits-1:0] r_shamt;
  logic [SBits-1:0] r_stage;
  logic [NBits-1:0] r_result;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_state_nxt;
  logic [NBits-1:0] w_acc_nxt;
  logic [SBits-1:0] w_shamt_nxt;
  logic [SBits-1:0] w_stage_nxt;
  logic [NBits-1:0] w_result_nxt;

  // Shift distance of the current stage: 2**stage.
  logic [SBits-1:0] w_amt;
  logic [NBits-1:0] w_shl;
  logic [NBits-1:0] w_stepped;

  assign w_amt = SBits'(1) << r_stage;
  assign w_shl = r_acc << w_amt;

`ifdef SLL_ROTATE_EN
  logic             r_rot;
  logic             w_rot_nxt;
  logic [SBits-1:0] w_ramt;

  // Bits leaving the MSB re-enter at the LSB; w_amt >= 1 keeps w_ramt in range.
  assign w_ramt    = SBits'(NBits - 32'(w_amt));
  assign w_stepped = r_rot ? (w_shl | (r_acc >> w_ramt)) : w_shl;
`else
  assign w_stepped = w_shl;
`endif

  // State and datapath registers; reset wins over any start in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_shamt  <= '0;
      r_stage  <= STAGE_FIRST;
      r_result <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SLL_ROTATE_EN
      r_rot    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_shamt  <= w_shamt_nxt;
      r_stage  <= w_stage_nxt;
      r_result <= w_result_nxt;
      // Status flags are registered copies of the next state.
      r_ready  <= (w_state_nxt == ST_IDLE);
      r_busy   <= (w_state_nxt == ST_SHIFT);
      r_done   <= (w_state_nxt == ST_DONE);
`ifdef SLL_ROTATE_EN
      r_rot    <= w_rot_nxt;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_shamt_nxt  = r_shamt;
    w_stage_nxt  = r_stage;
    w_result_nxt = r_result;
`ifdef SLL_ROTATE_EN
    w_rot_nxt    = r_rot;
`endif
    case (r_state)
      ST_IDLE: begin
        if (in_start) begin
          w_acc_nxt   = in_data_32;
          w_shamt_nxt = in_shamt_5;
          w_stage_nxt = STAGE_FIRST;
`ifdef SLL_ROTATE_EN
          w_rot_nxt   = in_rotate;
`endif
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_acc_nxt = r_shamt[r_stage] ? w_stepped : r_acc;
        if (r_stage == '0) begin
          // Publish only the final value so partial stages never show.
          w_result_nxt = w_acc_nxt;
          w_state_nxt  = ST_DONE;
        end else begin
          w_stage_nxt = r_stage - SBits'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign out_ready           = r_ready;
  assign out_busy            = r_busy;
  assign out_done            = r_done;
  assign out_shifted_data_32 = r_result;

endmodule
